// File: rtl/queen_solution_streamer.sv
// Captures a finished 8-queens board and streams it out one row per valid/ready beat.
// Optional build macro QUEEN_ONEHOT_CHECK_EN adds a per-row one-hot check driving out_err.
module queen_solution_streamer #(
   parameter int N     = 8,
   parameter int IDX_W = 3,
   parameter int CNT_W = 8
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [N*N-1:0]     board_in,
   input  logic               sol_valid,
   output logic               sol_ack,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [IDX_W-1:0]   out_row,
   output logic [IDX_W-1:0]   out_col,
   output logic               out_last,
   output logic               out_err,
   output logic               busy,
   output logic [CNT_W-1:0]   sol_count
);

   typedef enum logic [0:0] {IDLE = 1'b0, SEND = 1'b1} state_t;

   state_t             state_r;
   logic [N*N-1:0]     shadow_r;
   logic [IDX_W-1:0]   row_r;
   logic [IDX_W-1:0]   col_r;
   logic               valid_r;
   logic               last_r;
   logic               busy_r;
   logic [CNT_W-1:0]   count_r;

   logic               capture_s;
   logic               xfer_s;
   logic [IDX_W-1:0]   next_row_s;
   logic [N-1:0]       next_bits_s;

   function automatic logic [N-1:0] row_of(input logic [N*N-1:0] b, input logic [IDX_W-1:0] r);
      row_of = b[N*int'(r) +: N];
   endfunction

   // Lowest set bit wins; an empty row encodes as column 0.
   function automatic logic [IDX_W-1:0] enc(input logic [N-1:0] v);
      enc = '0;
      for (int i = N - 1; i >= 0; i--) begin
         if (v[i]) enc = IDX_W'(i);
         else      enc = enc;
      end
   endfunction

   // Handshake decode and lookahead of the next row to be presented.
   always_comb begin
      capture_s   = (state_r == IDLE) && sol_valid;
      xfer_s      = valid_r && out_ready;
      next_row_s  = row_r + IDX_W'(1);
      next_bits_s = row_of(shadow_r, next_row_s);
   end

   // sol_ack must fall in the same IDLE cycle that samples board_in, so it is decoded
   // from the state register rather than registered a cycle late.
   assign sol_ack   = capture_s;
   assign out_valid = valid_r;
   assign out_row   = row_r;
   assign out_col   = col_r;
   assign out_last  = last_r;
   assign busy      = busy_r;
   assign sol_count = count_r;

   // Capture/stream FSM with registered beat fields.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_r  <= IDLE;
         shadow_r <= '0;
         row_r    <= '0;
         col_r    <= '0;
         valid_r  <= 1'b0;
         last_r   <= 1'b0;
         busy_r   <= 1'b0;
         count_r  <= '0;
      end else begin
         case (state_r)
            IDLE: begin
               if (capture_s) begin
                  shadow_r <= board_in;
                  row_r    <= '0;
                  col_r    <= enc(board_in[N-1:0]);
                  last_r   <= (N == 1);
                  valid_r  <= 1'b1;
                  busy_r   <= 1'b1;
                  state_r  <= SEND;
               end else begin
                  state_r  <= IDLE;
               end
            end
            SEND: begin
               if (xfer_s && last_r) begin
                  count_r  <= count_r + CNT_W'(1);
                  row_r    <= '0;
                  col_r    <= '0;
                  last_r   <= 1'b0;
                  valid_r  <= 1'b0;
                  busy_r   <= 1'b0;
                  state_r  <= IDLE;
               end else if (xfer_s) begin
                  row_r    <= next_row_s;
                  col_r    <= enc(next_bits_s);
                  last_r   <= (next_row_s == IDX_W'(N - 1));
               end else begin
                  state_r  <= SEND;
               end
            end
            default: begin
               state_r <= IDLE;
               valid_r <= 1'b0;
               busy_r  <= 1'b0;
            end
         endcase
      end
   end

`ifdef QUEEN_ONEHOT_CHECK_EN
   logic err_r;

   function automatic logic not_onehot(input logic [N-1:0] v);
      int cnt;
      cnt = 0;
      for (int i = 0; i < N; i++) begin
         if (v[i]) cnt = cnt + 1;
         else      cnt = cnt;
      end
      not_onehot = (cnt != 1);
   endfunction

   // Error flag tracks the row currently presented on the beat.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         err_r <= 1'b0;
      end else if (capture_s) begin
         err_r <= not_onehot(board_in[N-1:0]);
      end else if (state_r == SEND && xfer_s && last_r) begin
         err_r <= 1'b0;
      end else if (state_r == SEND && xfer_s) begin
         err_r <= not_onehot(next_bits_s);
      end else begin
         err_r <= err_r;
      end
   end

   assign out_err = err_r;
`else
   assign out_err = 1'b0;
`endif

endmodule
